// File: rtl/alu_exec.sv
// Single-issue ALU execution stage with valid/ready handshakes on both sides.
// Operands are captured on acceptance, computed in EXEC and held in HOLD until consumed.
module alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [15:0]      op_count
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [CTRL_W-1:0]   ctrl_q,      ctrl_d;
    logic [WIDTH-1:0]    a_q,         a_d;
    logic [WIDTH-1:0]    b_q,         b_d;
    logic [WIDTH-1:0]    result_q,    result_d;
    logic                zero_q,      zero_d;
    logic                overflow_q,  overflow_d;
    logic                illegal_q,   illegal_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    op_count_q,  op_count_d;

    logic [WIDTH-1:0]    sum_c;
    logic [WIDTH-1:0]    diff_c;
    logic                add_ovf_c;
    logic                sub_ovf_c;
    logic                slt_c;
    logic [WIDTH-1:0]    alu_res_c;
    logic                alu_ovf_c;
    logic                alu_ill_c;

    // Arithmetic on the captured operands; SLT uses the true sign of a-b (sign xor overflow)
    always_comb begin
        sum_c     = a_q + b_q;
        diff_c    = a_q - b_q;
        add_ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1]  != a_q[WIDTH-1]);
        sub_ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
        slt_c     = diff_c[WIDTH-1] ^ sub_ovf_c;
    end

    // Operation decode; unsupported codes yield a zero result flagged illegal
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        alu_ill_c = 1'b0;
        case (ctrl_q)
            CTRL_AND: alu_res_c = a_q & b_q;
            CTRL_OR:  alu_res_c = a_q | b_q;
            CTRL_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = add_ovf_c;
            end
            CTRL_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = sub_ovf_c;
            end
            CTRL_SLT: alu_res_c = WIDTH'(slt_c);
            CTRL_NOR: alu_res_c = ~(a_q | b_q);
            default:  alu_ill_c = 1'b1;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d  = alu_ctrl;
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_res_c;
                zero_d      = (alu_res_c == '0);
                overflow_d  = alu_ovf_c;
                illegal_d   = alu_ill_c;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (op_count_q != CNT_MAX) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    // Ready depends on state alone, so it never loops back from in_valid
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign op_count  = op_count_q;

endmodule
